micro_sequencer: RTL and testbench

Next-state engine of the microprogrammed control unit. It holds the current microstore address `State`, and the microstore returns the 44-bit control word for that address. From that word's sequencing fields (`N`, `S`, `Inv`, `CR`, `IncRld`), the datapath status inputs and the instruction opcode, it computes the address of the next microinstruction. It sits between the microstore and the control register: it produces the address whose word the control register latches.

---
 rtl/control_pkg.sv | 35 +++
 rtl/opcode_encoder.sv | 26 ++
 rtl/micro_sequencer.sv | 77 +++++++
 tb/tb_micro_sequencer.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// Shared encodings for the microprogrammed control unit: sequencing field codes,
// well-known microstore addresses and the instruction opcodes that dispatch to them.
package control_pkg;

    localparam logic [2:0] N_ENC     = 3'b000;
    localparam logic [2:0] N_CR      = 3'b001;
    localparam logic [2:0] N_INC     = 3'b010;
    localparam logic [2:0] N_CR_INC  = 3'b011;
    localparam logic [2:0] N_CR_ENC  = 3'b100;
    localparam logic [2:0] N_ENC_INC = 3'b101;
    localparam logic [2:0] N_RESET   = 3'b110;
    localparam logic [2:0] N_HOLD    = 3'b111;

    localparam logic [1:0] S_MOC  = 2'b00;
    localparam logic [1:0] S_COND = 2'b01;
    localparam logic [1:0] S_ZERO = 2'b10;
    localparam logic [1:0] S_ONE  = 2'b11;

    localparam int ST_RESET   = 0;
    localparam int ST_RTYPE   = 10;
    localparam int ST_ADDI    = 20;
    localparam int ST_LW      = 30;
    localparam int ST_SW      = 40;
    localparam int ST_BEQ     = 50;
    localparam int ST_J       = 60;
    localparam int ST_ILLEGAL = 127;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

endpackage

// File: rtl/opcode_encoder.sv
// Maps the instruction opcode to the entry address of its microcode routine;
// unknown opcodes land on the illegal-instruction handler.
module opcode_encoder
    import control_pkg::*;
#(
    parameter int STATE_W = 7
) (
    input  logic [5:0]         opcode,
    output logic [STATE_W-1:0] addr
);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        addr = STATE_W'(ST_ILLEGAL);
        case (opcode)
            OP_RTYPE: addr = STATE_W'(ST_RTYPE);
            OP_ADDI:  addr = STATE_W'(ST_ADDI);
            OP_LW:    addr = STATE_W'(ST_LW);
            OP_SW:    addr = STATE_W'(ST_SW);
            OP_BEQ:   addr = STATE_W'(ST_BEQ);
            OP_J:     addr = STATE_W'(ST_J);
            default:  addr = STATE_W'(ST_ILLEGAL);
        endcase
    end

endmodule

// File: rtl/micro_sequencer.sv
// Next-address engine: selects the following microstore address from the current
// word's sequencing fields, datapath status and the opcode dispatch table.
module micro_sequencer
    import control_pkg::*;
#(
    parameter int STATE_W     = 7,
    parameter int RESET_STATE = 0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [2:0]         N,
    input  logic [1:0]         S,
    input  logic               IncRld,
    input  logic               Inv,
    input  logic [STATE_W-1:0] CR,
    input  logic               MOC,
    input  logic               Cond,
    input  logic [5:0]         Opcode,
    output logic [STATE_W-1:0] State
);

    localparam logic [STATE_W-1:0] RESET_ADDR = STATE_W'(RESET_STATE);
    localparam logic [STATE_W-1:0] RESET_INC  = STATE_W'(RESET_STATE + 1);

    logic [STATE_W-1:0] inc_reg;
    logic [STATE_W-1:0] enc_addr;
    logic [STATE_W-1:0] next_state;
    logic               sel;
    logic               cond;

    opcode_encoder #(.STATE_W(STATE_W)) u_encoder (
        .opcode (Opcode),
        .addr   (enc_addr)
    );

    always_comb begin
        sel = 1'b0;
        case (S)
            S_MOC:   sel = MOC;
            S_COND:  sel = Cond;
            S_ZERO:  sel = 1'b0;
            S_ONE:   sel = 1'b1;
            default: sel = 1'b0;
        endcase
        cond = sel ^ Inv;
    end

    always_comb begin
        next_state = State;
        case (N)
            N_ENC:     next_state = enc_addr;
            N_CR:      next_state = CR;
            N_INC:     next_state = inc_reg;
            N_CR_INC:  next_state = cond ? CR : inc_reg;
            N_CR_ENC:  next_state = cond ? CR : enc_addr;
            N_ENC_INC: next_state = cond ? enc_addr : inc_reg;
            N_RESET:   next_state = RESET_ADDR;
            N_HOLD:    next_state = State;
            default:   next_state = State;
        endcase
    end

    // The incrementer tracks the address being entered, so a later N_INC resumes
    // right after it even when State itself is held.
    // NOTE: registers use non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            State   <= RESET_ADDR;
            inc_reg <= RESET_INC;
        end else begin
            State <= next_state;
            if (IncRld)
                inc_reg <= next_state + STATE_W'(1);
        end
    end

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench: the driver queues the expected State for each edge it issues,
// and a monitor compares it shortly after that edge.
module tb_micro_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [2:0] N;
    logic [1:0] S;
    logic       IncRld;
    logic       Inv;
    logic [6:0] CR;
    logic       MOC;
    logic       Cond;
    logic [5:0] Opcode;
    logic [6:0] State;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [6:0] exp;
        string      name;
    } exp_t;

    exp_t sb_q[$];

    micro_sequencer #(.STATE_W(7), .RESET_STATE(0)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .N       (N),
        .S       (S),
        .IncRld  (IncRld),
        .Inv     (Inv),
        .CR      (CR),
        .MOC     (MOC),
        .Cond    (Cond),
        .Opcode  (Opcode),
        .State   (State)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: State=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: State is valid every cycle after a queued edge.
    always @(posedge clk) begin
        #2;
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check(e.name, State, e.exp);
        end
    end

    task automatic step(input logic [2:0] n, input logic [1:0] s, input logic incrld,
                        input logic inv, input logic [6:0] cr, input logic moc,
                        input logic cnd, input logic [5:0] op,
                        input logic [6:0] exp, input string name);
        exp_t e;
        @(negedge clk);
        N = n; S = s; IncRld = incrld; Inv = inv; CR = cr;
        MOC = moc; Cond = cnd; Opcode = op;
        e.exp  = exp;
        e.name = name;
        sb_q.push_back(e);
    endtask

    initial begin
        reset_n = 1'b0;
        N = 3'b111; S = 2'b00; IncRld = 1'b0; Inv = 1'b0; CR = '0;
        MOC = 1'b0; Cond = 1'b0; Opcode = 6'h00;
        #1;
        check("reset_state", State, 7'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Increment from reset
        step(3'b010, 2'b00, 1'b1, 1'b0, 7'd0, 1'b0, 1'b0, 6'h00, 7'd1, "inc_1");
        step(3'b010, 2'b00, 1'b1, 1'b0, 7'd0, 1'b0, 1'b0, 6'h00, 7'd2, "inc_2");
        step(3'b010, 2'b00, 1'b1, 1'b0, 7'd0, 1'b0, 1'b0, 6'h00, 7'd3, "inc_3");

        // Mid-cycle asynchronous reset, then hold through an edge
        @(negedge clk);
        N = 3'b111; IncRld = 1'b0;
        #2 reset_n = 1'b0;
        #1 check("async_reset", State, 7'd0);
        @(posedge clk);
        #1 check("reset_hold", State, 7'd0);
        @(negedge clk);
        reset_n = 1'b1;
        step(3'b010, 2'b00, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0, 6'h00, 7'd1, "increg_reset_val");

        // MOC wait loop at state 5
        step(3'b001, 2'b00, 1'b1, 1'b0, 7'd5, 1'b0, 1'b0, 6'h00, 7'd5, "goto_5");
        for (int i = 0; i < 3; i++)
            step(3'b011, 2'b00, 1'b1, 1'b1, 7'd5, 1'b0, 1'b0, 6'h00, 7'd5, "moc_wait");
        step(3'b011, 2'b00, 1'b1, 1'b1, 7'd5, 1'b1, 1'b0, 6'h00, 7'd6, "moc_done");

        // Decode dispatch
        step(3'b000, 2'b00, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0, 6'h23, 7'd30,  "dec_lw");
        step(3'b000, 2'b00, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0, 6'h3F, 7'd127, "dec_illegal");
        step(3'b000, 2'b00, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0, 6'h00, 7'd10,  "dec_rtype");
        step(3'b000, 2'b00, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0, 6'h08, 7'd20,  "dec_addi");
        step(3'b000, 2'b00, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0, 6'h2B, 7'd40,  "dec_sw");
        step(3'b000, 2'b00, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0, 6'h04, 7'd50,  "dec_beq");
        step(3'b000, 2'b00, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0, 6'h02, 7'd60,  "dec_j");

        // Wrap-around of the incrementer
        step(3'b001, 2'b00, 1'b1, 1'b0, 7'd126, 1'b0, 1'b0, 6'h00, 7'd126, "goto_126");
        step(3'b010, 2'b00, 1'b1, 1'b0, 7'd0,   1'b0, 1'b0, 6'h00, 7'd127, "wrap_127");
        step(3'b010, 2'b00, 1'b1, 1'b0, 7'd0,   1'b0, 1'b0, 6'h00, 7'd0,   "wrap_0");
        step(3'b010, 2'b00, 1'b1, 1'b0, 7'd0,   1'b0, 1'b0, 6'h00, 7'd1,   "wrap_1");

        // Frozen incrementer
        step(3'b001, 2'b00, 1'b1, 1'b0, 7'd8, 1'b0, 1'b0, 6'h00, 7'd8, "goto_8");
        for (int i = 0; i < 3; i++)
            step(3'b010, 2'b00, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0, 6'h00, 7'd9, "frozen_inc");

        // Forced branch, hold, hold-with-load, reset code
        step(3'b011, 2'b10, 1'b0, 1'b1, 7'd42, 1'b0, 1'b0, 6'h00, 7'd42, "forced_branch");
        step(3'b111, 2'b00, 1'b0, 1'b0, 7'd0,  1'b0, 1'b0, 6'h00, 7'd42, "hold_1");
        step(3'b111, 2'b00, 1'b0, 1'b0, 7'd0,  1'b0, 1'b0, 6'h00, 7'd42, "hold_2");
        step(3'b111, 2'b00, 1'b1, 1'b0, 7'd0,  1'b0, 1'b0, 6'h00, 7'd42, "hold_load");
        step(3'b010, 2'b00, 1'b0, 1'b0, 7'd0,  1'b0, 1'b0, 6'h00, 7'd43, "after_hold_load");
        step(3'b110, 2'b00, 1'b0, 1'b0, 7'd99, 1'b1, 1'b1, 6'h00, 7'd0,  "n_reset");

        // Remaining conditional modes and condition sources
        step(3'b100, 2'b11, 1'b1, 1'b0, 7'd77, 1'b0, 1'b0, 6'h00, 7'd77, "cr_enc_taken");
        step(3'b100, 2'b01, 1'b0, 1'b0, 7'd77, 1'b0, 1'b0, 6'h02, 7'd60, "cr_enc_not");
        step(3'b101, 2'b01, 1'b0, 1'b0, 7'd0,  1'b0, 1'b1, 6'h08, 7'd20, "enc_inc_taken");
        step(3'b101, 2'b01, 1'b0, 1'b1, 7'd0,  1'b0, 1'b1, 6'h08, 7'd78, "enc_inc_inv");
        step(3'b011, 2'b01, 1'b0, 1'b0, 7'd3,  1'b0, 1'b1, 6'h00, 7'd3,  "cr_inc_cond");
        step(3'b011, 2'b00, 1'b0, 1'b0, 7'd3,  1'b1, 1'b0, 6'h00, 7'd3,  "cr_inc_moc");

        for (int i = 0; i < 20 && sb_q.size() > 0; i++)
            @(posedge clk);
        #5;
        if (sb_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: pending=%0d expected=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
